// File: rtl/wb_pkg.sv
// Shared WISHBONE definitions: bus widths, FSM state and termination encodings.
package wb_pkg;

  localparam int WB_ADR_W = 20;
  localparam int WB_DAT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } fsm_state_t;

  typedef enum logic [1:0] {
    TERM_ACK = 2'd0,
    TERM_ERR = 2'd1,
    TERM_RTY = 2'd2
  } term_t;

  // An access that would ack is turned into a retry while the fabric is busy;
  // an error keeps its priority.
  function automatic term_t apply_busy(term_t base, logic busy);
    return (base == TERM_ACK && busy) ? TERM_RTY : base;
  endfunction

endpackage

// File: rtl/wb_reg_slave_if.sv
// Classic WISHBONE slave bus bundle; names follow the slave's point of view.
interface wb_reg_slave_if;
  import wb_pkg::*;

  logic                cyc_i;
  logic                stb_i;
  logic                we_i;
  logic [WB_ADR_W-1:0] adr_i;
  logic [WB_DAT_W-1:0] dat_i;
  logic [WB_DAT_W-1:0] dat_o;
  logic                ack_o;
  logic                err_o;
  logic                rty_o;

  modport master (
    output cyc_i, stb_i, we_i, adr_i, dat_i,
    input  dat_o, ack_o, err_o, rty_o
  );

  modport slave (
    input  cyc_i, stb_i, we_i, adr_i, dat_i,
    output dat_o, ack_o, err_o, rty_o
  );

endinterface

// File: rtl/wb_term_fsm.sv
// Request/latency/termination FSM for the register slave.
// Optional feature macro: WB_REG_SLAVE_RETRY_EN (busy turns an ack into a retry).
module wb_term_fsm
  import wb_pkg::*;
#(
  parameter int ACK_LATENCY = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  cyc,
  input  logic  stb,
  input  logic  busy,
  input  term_t base_term,
  output logic  capture,
  output logic  ack,
  output logic  err,
  output logic  rty
);

  fsm_state_t state_reg, state_next;
  logic [3:0] count_reg, count_next;
  term_t      term_reg, term_next;
  logic       busy_eff;

`ifdef WB_REG_SLAVE_RETRY_EN
  assign busy_eff = busy;
`else
  logic unused_busy;
  assign unused_busy = busy;
  assign busy_eff    = 1'b0;
`endif

  assign capture = (state_reg == ST_IDLE) && cyc && stb;

  // State, latency counter and resolved termination registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      count_reg <= 4'd0;
      term_reg  <= TERM_ACK;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      term_reg  <= term_next;
    end
  end

  // Next state: accept, count down the latency, abort when cyc drops.
  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    term_next  = term_reg;
    case (state_reg)
      ST_IDLE: begin
        if (cyc && stb) begin
          if (ACK_LATENCY == 1) begin
            state_next = ST_RESP;
            term_next  = apply_busy(base_term, busy_eff);
          end else begin
            state_next = ST_WAIT;
            count_next = 4'(ACK_LATENCY - 1);
            term_next  = base_term;
          end
        end
      end
      ST_WAIT: begin
        if (!cyc) begin
          state_next = ST_IDLE;
          count_next = 4'd0;
        end else if (count_reg == 4'd1) begin
          state_next = ST_RESP;
          count_next = 4'd0;
          // busy is judged at the moment the response is committed
          term_next  = apply_busy(term_reg, busy_eff);
        end else begin
          count_next = count_reg - 4'd1;
        end
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
        count_next = 4'd0;
      end
    endcase
  end

  // Exactly one termination strobe during the single RESP cycle.
  always_comb begin
    ack = 1'b0;
    err = 1'b0;
    rty = 1'b0;
    if (state_reg == ST_RESP) begin
      case (term_reg)
        TERM_ERR: err = 1'b1;
        TERM_RTY: rty = 1'b1;
        default:  ack = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/wb_reg_slave.sv
// WISHBONE register bank slave: read-only ID at index 0, RW control registers above.
// Optional feature macro: WB_REG_SLAVE_RETRY_EN (busy_i converts an ack into rty_o).
module wb_reg_slave
  import wb_pkg::*;
#(
  parameter int                  ADDR_BITS   = 3,
  parameter logic [WB_ADR_W-1:0] BASE_ADR    = 20'h00000,
  parameter int                  ACK_LATENCY = 1,
  parameter logic [WB_DAT_W-1:0] ID_VAL      = 32'h53524631,
  parameter logic [WB_DAT_W-1:0] CTRL_RST    = 32'h00000000,
  localparam int                 NREG        = 2 ** ADDR_BITS
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  wb_reg_slave_if.slave            bus,
  input  logic                     busy_i,
  output logic [WB_DAT_W*NREG-1:0] ctrl_o,
  output logic [NREG-1:0]          wr_stb_o
);

  logic                 hit;
  logic [ADDR_BITS-1:0] idx;
  term_t                base_term;
  logic                 capture;
  logic                 ack;
  logic                 err;
  logic                 rty;
  logic                 wr_en;

  logic                 we_reg;
  logic [ADDR_BITS-1:0] idx_reg;
  logic [WB_DAT_W-1:0]  dat_reg;
  logic [WB_DAT_W-1:0]  slot [NREG];

  // Decode on the live bus; the result is latched by the FSM on acceptance.
  assign hit       = bus.adr_i[WB_ADR_W-1:ADDR_BITS] == BASE_ADR[WB_ADR_W-1:ADDR_BITS];
  assign idx       = bus.adr_i[ADDR_BITS-1:0];
  assign base_term = (!hit || (bus.we_i && idx == '0)) ? TERM_ERR : TERM_ACK;

  wb_term_fsm #(
    .ACK_LATENCY (ACK_LATENCY)
  ) u_fsm (
    .clk       (clk_i),
    .rst_n     (rst_n_i),
    .cyc       (bus.cyc_i),
    .stb       (bus.stb_i),
    .busy      (busy_i),
    .base_term (base_term),
    .capture   (capture),
    .ack       (ack),
    .err       (err),
    .rty       (rty)
  );

  // Hold the accepted request while the latency counter runs.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      we_reg  <= 1'b0;
      idx_reg <= '0;
      dat_reg <= '0;
    end else if (capture) begin
      we_reg  <= bus.we_i;
      idx_reg <= idx;
      dat_reg <= bus.dat_i;
    end
  end

  // Only an acked write commits; err/rty leave every register untouched.
  assign wr_en = ack && we_reg;

  assign bus.ack_o = ack;
  assign bus.err_o = err;
  assign bus.rty_o = rty;
  assign bus.dat_o = (ack && !we_reg) ? slot[idx_reg] : '0;

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_id
        assign slot[gi] = ID_VAL;
      end else begin : g_ctrl
        logic [WB_DAT_W-1:0] data_reg;
        // Control register: reset value, then written at the end of its ack cycle.
        always_ff @(posedge clk_i) begin
          if (!rst_n_i) begin
            data_reg <= CTRL_RST;
          end else if (wr_en && idx_reg == ADDR_BITS'(gi)) begin
            data_reg <= dat_reg;
          end
        end
        assign slot[gi] = data_reg;
      end
      assign wr_stb_o[gi]                    = wr_en && (idx_reg == ADDR_BITS'(gi));
      assign ctrl_o[gi*WB_DAT_W +: WB_DAT_W] = slot[gi];
    end
  endgenerate

endmodule

// File: tb/tb_wb_reg_slave.sv
// Directed self-checking bench for wb_reg_slave: one instance with ACK_LATENCY=1,
// one with ACK_LATENCY=4. Retry checks depend on WB_REG_SLAVE_RETRY_EN.
module tb_wb_reg_slave;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         busy;
  logic [255:0] ctrl1, ctrl4;
  logic [7:0]   wstb1, wstb4;

  int total = 0;
  int bad   = 0;

  wb_reg_slave_if bus1();
  wb_reg_slave_if bus4();

  always #5 clk = ~clk;

  wb_reg_slave #(.ACK_LATENCY(1)) dut1 (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .bus      (bus1),
    .busy_i   (busy),
    .ctrl_o   (ctrl1),
    .wr_stb_o (wstb1)
  );

  wb_reg_slave #(.ACK_LATENCY(4)) dut4 (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .bus      (bus4),
    .busy_i   (busy),
    .ctrl_o   (ctrl4),
    .wr_stb_o (wstb4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One classic cycle on the latency-1 instance. Called just after a posedge.
  // t0/d0/s0: termination {ack,err,rty}, dat_o, wr_stb in the response cycle;
  // t1/c1: termination and register image one cycle later.
  task automatic wb1(input logic we, input logic [19:0] adr, input logic [31:0] dat,
                     output logic [2:0] t0, output logic [31:0] d0, output logic [7:0] s0,
                     output logic [2:0] t1, output logic [255:0] c1);
    bus1.cyc_i = 1'b1;
    bus1.stb_i = 1'b1;
    bus1.we_i  = we;
    bus1.adr_i = adr;
    bus1.dat_i = dat;
    @(posedge clk); #1;
    t0 = {bus1.ack_o, bus1.err_o, bus1.rty_o};
    d0 = bus1.dat_o;
    s0 = wstb1;
    bus1.cyc_i = 1'b0;
    bus1.stb_i = 1'b0;
    bus1.we_i  = 1'b0;
    @(posedge clk); #1;
    t1 = {bus1.ack_o, bus1.err_o, bus1.rty_o};
    c1 = ctrl1;
    $display("L1 %s adr=%05h wdat=%08h term=%b rdat=%08h wr_stb=%b",
             we ? "WR" : "RD", adr, dat, t0, d0, s0);
  endtask

  initial begin
    logic [2:0]   t0, t1, tacc;
    logic [31:0]  d0;
    logic [7:0]   s0;
    logic [255:0] c1;

    rst_n = 1'b0;
    busy  = 1'b0;
    bus1.cyc_i = 1'b0; bus1.stb_i = 1'b0; bus1.we_i = 1'b0; bus1.adr_i = '0; bus1.dat_i = '0;
    bus4.cyc_i = 1'b0; bus4.stb_i = 1'b0; bus4.we_i = 1'b0; bus4.adr_i = '0; bus4.dat_i = '0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_term", {29'd0, bus1.ack_o, bus1.err_o, bus1.rty_o}, 32'd0);
    check("rst_dat", bus1.dat_o, 32'd0);
    check("rst_wstb", {24'd0, wstb1}, 32'd0);
    check("rst_slot0", ctrl1[31:0], 32'h53524631);
    check("rst_slot1", ctrl1[63:32], 32'h00000000);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Read ID
    wb1(1'b0, 20'h00000, 32'd0, t0, d0, s0, t1, c1);
    check("rd_id_term", {29'd0, t0}, 32'b100);
    check("rd_id_dat", d0, 32'h53524631);
    check("rd_id_term_next", {29'd0, t1}, 32'd0);

    // Write then read back register 2
    wb1(1'b1, 20'h00002, 32'hDEADBEEF, t0, d0, s0, t1, c1);
    check("wr2_term", {29'd0, t0}, 32'b100);
    check("wr2_wstb", {24'd0, s0}, 32'b00000100);
    check("wr2_dat_zero", d0, 32'd0);
    check("wr2_ctrl", c1[95:64], 32'hDEADBEEF);
    check("wr2_term_next", {29'd0, t1}, 32'd0);
    wb1(1'b0, 20'h00002, 32'd0, t0, d0, s0, t1, c1);
    check("rd2_dat", d0, 32'hDEADBEEF);

    // Write to the ID register is an error and changes nothing
    wb1(1'b1, 20'h00000, 32'h12345678, t0, d0, s0, t1, c1);
    check("wr_id_term", {29'd0, t0}, 32'b010);
    check("wr_id_wstb", {24'd0, s0}, 32'd0);
    check("wr_id_term_next", {29'd0, t1}, 32'd0);
    wb1(1'b0, 20'h00000, 32'd0, t0, d0, s0, t1, c1);
    check("rd_id_again", d0, 32'h53524631);

    // Out-of-window read
    wb1(1'b0, 20'h00010, 32'd0, t0, d0, s0, t1, c1);
    check("miss_term", {29'd0, t0}, 32'b010);
    check("miss_dat", d0, 32'd0);

    // Busy fabric
    busy = 1'b1;
    wb1(1'b1, 20'h00003, 32'hA5A5A5A5, t0, d0, s0, t1, c1);
`ifdef WB_REG_SLAVE_RETRY_EN
    check("busy_term", {29'd0, t0}, 32'b001);
    check("busy_wstb", {24'd0, s0}, 32'd0);
    check("busy_keep", c1[127:96], 32'h00000000);
    busy = 1'b1;
    wb1(1'b0, 20'h00001, 32'd0, t0, d0, s0, t1, c1);
    check("busy_rd_term", {29'd0, t0}, 32'b001);
    check("busy_rd_dat", d0, 32'd0);
    wb1(1'b1, 20'h00000, 32'h1, t0, d0, s0, t1, c1);
    check("busy_err_prio", {29'd0, t0}, 32'b010);
    busy = 1'b0;
    wb1(1'b1, 20'h00003, 32'hA5A5A5A5, t0, d0, s0, t1, c1);
`endif
    check("wr3_term", {29'd0, t0}, 32'b100);
    check("wr3_ctrl", c1[127:96], 32'hA5A5A5A5);
    busy = 1'b0;

    // Latency 4: write register 5, ack only in the 4th sampled cycle
    bus4.cyc_i = 1'b1; bus4.stb_i = 1'b1; bus4.we_i = 1'b1;
    bus4.adr_i = 20'h00005; bus4.dat_i = 32'hCAFEF00D;
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("l4_wr_ack_c%0d", c), {31'd0, bus4.ack_o}, {31'd0, c == 4});
      if (c == 4) begin
        check("l4_wr_wstb", {24'd0, wstb4}, 32'b00100000);
        bus4.cyc_i = 1'b0; bus4.stb_i = 1'b0; bus4.we_i = 1'b0;
      end
    end
    check("l4_wr_ctrl", ctrl4[191:160], 32'hCAFEF00D);
    $display("L4 WR adr=00005 wdat=cafef00d");

    // Latency 4: read back register 5
    bus4.cyc_i = 1'b1; bus4.stb_i = 1'b1; bus4.adr_i = 20'h00005;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      if (c == 4) begin
        check("l4_rd_ack", {31'd0, bus4.ack_o}, 32'd1);
        check("l4_rd_dat", bus4.dat_o, 32'hCAFEF00D);
        bus4.cyc_i = 1'b0; bus4.stb_i = 1'b0;
      end
    end
    @(posedge clk); #1;
    $display("L4 RD adr=00005 rdat=cafef00d");

    // Latency 4: abort by dropping cyc before the response
    bus4.cyc_i = 1'b1; bus4.stb_i = 1'b1; bus4.we_i = 1'b1;
    bus4.adr_i = 20'h00006; bus4.dat_i = 32'h0BADBEEF;
    tacc = 3'b000;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      tacc |= {bus4.ack_o, bus4.err_o, bus4.rty_o};
      if (c == 2) begin
        bus4.cyc_i = 1'b0; bus4.stb_i = 1'b0; bus4.we_i = 1'b0;
      end
    end
    check("l4_abort_term", {29'd0, tacc}, 32'd0);
    check("l4_abort_ctrl", ctrl4[223:192], 32'h00000000);
    $display("L4 WR adr=00006 aborted term=%b", tacc);

    // Reset clears the control registers and abandons an in-flight transfer
    wb1(1'b1, 20'h00001, 32'h11111111, t0, d0, s0, t1, c1);
    check("wr1_ctrl", c1[63:32], 32'h11111111);
    bus4.cyc_i = 1'b1; bus4.stb_i = 1'b1; bus4.we_i = 1'b1;
    bus4.adr_i = 20'h00007; bus4.dat_i = 32'h77777777;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    bus4.cyc_i = 1'b0; bus4.stb_i = 1'b0; bus4.we_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_slot1", ctrl1[63:32], 32'h00000000);
    check("rst_slot2", ctrl1[95:64], 32'h00000000);
    tacc = {bus1.ack_o, bus1.err_o, bus1.rty_o} | {bus4.ack_o, bus4.err_o, bus4.rty_o};
    for (int c = 1; c <= 5; c++) begin
      @(posedge clk); #1;
      tacc |= {bus4.ack_o, bus4.err_o, bus4.rty_o};
    end
    check("rst_term_after", {29'd0, tacc}, 32'd0);
    check("rst_l4_slot7", ctrl4[255:224], 32'h00000000);
    check("rst_l4_slot5", ctrl4[191:160], 32'h00000000);
    $display("RESET mid-transfer term=%b", tacc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_reg_slave.md
Name: wb_reg_slave

Overview:
- WISHBONE slave register bank; the responder end of the VIO-to-WISHBONE master bridge.
- Decodes a 20-bit word address window.
- Serves one ID register plus RW control registers, exposed to fabric logic.
- Terminates each cycle with exactly one of ack/err/rty after a programmable latency.
- One outstanding transfer; classic (non-pipelined) WISHBONE.

Parameters:
- ADDR_BITS, 3, register index width; NREG = 2**ADDR_BITS.
- BASE_ADR, 20'h00000, window base; must be aligned to NREG.
- ACK_LATENCY, 1, cycles from request sample to termination (1..15).
- ID_VAL, 32'h53524631, read-only contents of register 0.
- CTRL_RST, 32'h00000000, reset value of registers 1..NREG-1.

Ports:
- clk_i  in  1  system clock.
- rst_n_i  in  1  synchronous active-low reset.
- cyc_i  in  1  WISHBONE cycle.
- stb_i  in  1  WISHBONE strobe.
- we_i  in  1  write enable.
- adr_i  in  20  word address.
- dat_i  in  32  write data.
- dat_o  out  32  read data.
- ack_o  out  1  normal termination.
- err_o  out  1  error termination.
- rty_o  out  1  retry termination.
- busy_i  in  1  fabric hold-off request; used only with WB_REG_SLAVE_RETRY_EN.
- ctrl_o  out  32*NREG  flattened register image; slot 0 = ID_VAL.
- wr_stb_o  out  NREG  one-cycle write pulse per register.

Behaviour:
- Reset (rst_n_i low at a clock edge):
  - ack_o/err_o/rty_o = 0; dat_o = 0; wr_stb_o = 0.
  - Registers 1..NREG-1 = CTRL_RST.
  - FSM -> IDLE; latency counter = 0.
- Reset mid-transfer: abandon the transfer; no termination; no write.
- FSM states:
  - IDLE: on cyc_i & stb_i, capture we_i/adr_i/dat_i. Go to RESP if ACK_LATENCY==1, else WAIT with count = ACK_LATENCY-1.
  - WAIT: decrement count; at count==1 go to RESP.
  - RESP: exactly one termination signal is high for one cycle, then IDLE.
- Latency:
  - Request sampled at edge k → termination high during the cycle after edge k+ACK_LATENCY-1.
  - ACK_LATENCY=1 gives a one-cycle turnaround.
- Termination never repeats back-to-back for one request. IDLE is re-entered while stb_i drops, because the master clears stb on ack.
- Abort: cyc_i low in WAIT or RESP entry → return to IDLE, no termination, no write.
- Decode:
  - hit = adr_i[19:ADDR_BITS] == BASE_ADR[19:ADDR_BITS].
  - idx = adr_i[ADDR_BITS-1:0].
- Termination select, in priority order:
  - miss → err_o.
  - Write to idx 0 → err_o; register unchanged.
  - Otherwise → ack_o.
- Writes: register idx <= captured dat_i at the end of the RESP cycle. wr_stb_o[idx] is high during that same cycle.
- Reads: dat_o = register idx (ID_VAL for idx 0) during the ack_o cycle only. dat_o = 0 on err/rty and at all other times.
- ctrl_o updates the cycle after the write commit; otherwise it is stable.

Optional Feature:
- WB_REG_SLAVE_RETRY_EN defined:
  - busy_i is sampled at RESP entry.
  - If busy_i is high and the access would otherwise ack, rty_o is asserted instead of ack_o: no write, dat_o = 0.
  - err_o keeps priority over rty_o.
- Undefined: busy_i is ignored and rty_o is tied 0.

Decomposition:
- Shared package (wb_pkg):
  - WB_ADR_W=20 and WB_DAT_W=32.
  - FSM state encoding IDLE/WAIT/RESP.
  - Termination enum ACK/ERR/RTY.
- One natural sub-module: wb_term_fsm, holding the latency counter plus FSM and producing the single-cycle termination. The register array stays in the top.

Test Plan:
- Reset, then read adr 0x00000 with ACK_LATENCY=1 → ack_o high for exactly 1 cycle, 1 cycle after stb sampled; dat_o=32'h53524631.
- Write 32'hDEADBEEF to adr 0x00002, then read back → wr_stb_o=8'b00000100 during ack; ctrl_o[95:64]=32'hDEADBEEF next cycle; read returns 32'hDEADBEEF.
- Write 0x12345678 to adr 0x00000 → err_o for 1 cycle; ID still reads 32'h53524631. Read adr 0x00010 → err_o, dat_o=0.
- ACK_LATENCY=4: request at edge k → ack_o high only in the cycle after edge k+3. Drop cyc_i at k+2 → no ack_o and no write.
- With WB_REG_SLAVE_RETRY_EN and busy_i=1, write 0xA5A5A5A5 to adr 0x00003 → rty_o 1 cycle; register keeps CTRL_RST. Repeat with busy_i=0 → ack_o; ctrl_o[127:96]=0xA5A5A5A5.
- Write adr 0x00001, then assert rst_n_i=0 for 1 cycle → ctrl_o slot1=CTRL_RST; all termination outputs 0.
